sample_mix_scheduler: RTL and testbench
=======================================

# sample_mix_scheduler

Frame scheduler that shares the single 24-bit sample input of the PMOD I2S2 output path between several audio sources (vocoder bands, synth voices, passthrough). Once per sample period it polls each enabled source in turn over a valid/ready handshake, sums the returned samples with saturation, and presents one held sample to `pmod_i2s2.sample_in` with a one-cycle strobe. It also reports per-source underruns.

## Interface
- `N_SRC`, 4: number of requesting sources, 2..8.
- `WIDTH`, 24: signed two's-complement sample width.
- `PERIOD`, 768: `clk_in` cycles per output sample, i.e. 192 mclk periods. Must satisfy `PERIOD >= N_SRC+2`, enforced by an elaboration-time assertion.

Ports:
- `clk_in`  in  1  system clock, the only clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `src_en`  in  N_SRC  per-source enable mask, sampled at frame start.
- `src_valid`  in  N_SRC  source i has a sample available.
- `src_data`  in  N_SRC×WIDTH  packed samples; source i occupies `[i*WIDTH +: WIDTH]`.
- `src_ready`  out  N_SRC  one-hot; pulses when source i is polled.
- `clr_underrun`  in  1  single-cycle clear for the underrun flags.
- `sample_out`  out  WIDTH  mixed sample; drives `pmod_i2s2.sample_in`.
- `sample_strobe`  out  1  one-cycle pulse when `sample_out` updates.
- `underrun`  out  N_SRC  sticky per-source flag: source was polled while `src_valid` was 0.

## Operation
- Period counter runs 0..PERIOD-1 and wraps. `tick` = (count == PERIOD-1).
- FSM states:
  - IDLE: on `tick`, go to SCAN, set idx=0 and acc=0, latch `src_en` into `en_q`.
  - SCAN: one source per cycle. If `en_q[idx]`:
    - Assert `src_ready[idx]`.
    - If `src_valid[idx]`, do acc += sign-extended `src_data[idx]`. A transfer is complete when ready and valid are both high.
    - Otherwise set `underrun[idx]`.
  - SCAN, disabled source: no ready and no underrun, but it still takes its cycle, so frame timing is fixed.
  - SCAN exit: at idx == N_SRC-1, go to SAT.
  - SAT: saturate acc to WIDTH bits and register it into `sample_out`. Pulse `sample_strobe`. Go to IDLE.
- Width rules:
  - acc width is WIDTH + $clog2(N_SRC), signed.
  - Saturation bounds are +(2^(WIDTH-1))-1 and -2^(WIDTH-1).
  - For WIDTH=24 these are 0x7FFFFF and 0x800000.
- `sample_out` holds its value between strobes.
- `underrun` clears on `clr_underrun`. If set and clear occur in the same cycle, set wins.
- Sources with no valid data contribute 0, so a frame with no valid sources still strobes with `sample_out` = 0.

## Timing
- Reset values:
  - `sample_out` = 0, `sample_strobe` = 0, `src_ready` = 0, `underrun` = 0.
  - Counter = 0, FSM in IDLE.
- Per frame, with `tick` at cycle T:
  - `src_ready[i]` is high in cycle T+1+i.
  - SAT occurs in cycle T+1+N_SRC.
  - `sample_strobe` is high and the new `sample_out` is visible in cycle T+2+N_SRC.
  - Total latency from tick to strobe is N_SRC+2 cycles (6 for N_SRC=4).
- Strobe-to-strobe spacing is exactly PERIOD cycles. The first tick after reset release occurs at cycle PERIOD-1.
- `src_ready` is driven from registered state and idx only, with no combinational path from `src_valid`.
- Reset asserted mid-frame:
  - The frame aborts immediately and the partial sum is discarded.
  - No strobe is issued; all outputs return to their reset values.
  - The next frame starts PERIOD-1 cycles after release.
- `src_en` changes during SCAN have no effect until the next tick.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_WIDTH = 24`
  - `MCLK_DIV = 4`
  - `SAMPLES_PER_MCLK = 192`
  - the `mix_state_t` enum {IDLE, SCAN, SAT}
  - a `sat_trunc` function parameterised by the input and output widths.
- Natural sub-module: `sample_tick_gen`, the PERIOD counter producing `tick`, reusable by the future ADC capture scheduler.
- The rest (FSM, accumulator, underrun flags) lives in the top module.

## Test plan
All scenarios use N_SRC=4, PERIOD=768.
- All enabled and valid, data 1, 2, 3, 4 → `src_ready` walks 0001, 0010, 0100, 1000 in T+1..T+4; `sample_out` = 10 with strobe at T+6.
- Saturation:
  - all four = 0x7FFFFF → `sample_out` = 0x7FFFFF.
  - all four = 0x800000 → `sample_out` = 0x800000.
  - data 0x7FFFFF, 0x000001, 0x800000, 0 → `sample_out` = 0x000000.
- Underrun: `src_valid[2]` = 0, data 5, 6, 7, 8 → `sample_out` = 19 and `underrun` = 0100. The flag persists across frames until `clr_underrun`. Clear coinciding with a new underrun leaves the flag at 1.
- Enable mask: `src_en` = 0011, data 1, 2, 3, 4 → `src_ready[3:2]` never asserts, `underrun` stays 0, `sample_out` = 3.
- Reset at T+3 (mid-SCAN) → no strobe, `sample_out` = 0 and `src_ready` = 0 during reset. First post-release strobe lands at release + 767 + 6 with the correct sum.
- Strobe cadence over 32 frames with `src_data[0]` = frame index and the other sources valid with data 0 → strobes are exactly 768 cycles apart and `sample_out` follows 0..31.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, mclk ratios,
// mixer state encoding and a width-parameterised saturator.
package audio_pkg;

  localparam int SAMPLE_WIDTH     = 24;
  localparam int MCLK_DIV         = 4;
  localparam int SAMPLES_PER_MCLK = 192;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SAT
  } mix_state_t;

  // Clamp a sign-extended in_w-bit value into the out_w-bit signed range.
  function automatic logic signed [63:0] sat_trunc(
    input logic signed [63:0] val,
    input int                 in_w,
    input int                 out_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (in_w <= out_w) return val;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-period counter; tick marks the last cycle
// of each period.
module sample_tick_gen #(
  parameter int PERIOD = 768
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == CW'(PERIOD - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/sample_mix_scheduler.sv
// Polls each enabled source once per sample period, sums with
// saturation and presents one held sample with a strobe.
module sample_mix_scheduler
  import audio_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int PERIOD = SAMPLES_PER_MCLK * MCLK_DIV
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_SRC-1:0]         src_en,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  output logic [N_SRC-1:0]         src_ready,
  input  logic                     clr_underrun,
  output logic [WIDTH-1:0]         sample_out,
  output logic                     sample_strobe,
  output logic [N_SRC-1:0]         underrun
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int ACC_W = WIDTH + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SRC - 1);

  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
    $error("sample_mix_scheduler: N_SRC must be 2..8");
  end
  if (PERIOD < N_SRC + 2) begin : g_bad_period
    $error("sample_mix_scheduler: PERIOD must be >= N_SRC+2");
  end

  logic tick;

  sample_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .tick  (tick)
  );

  mix_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_SRC-1:0]        en_q, en_d;
  logic [N_SRC-1:0]        ready_q, ready_d;
  logic [N_SRC-1:0]        underrun_q, underrun_d;
  logic [N_SRC-1:0]        ur_set;
  logic [WIDTH-1:0]        sample_q, sample_d;
  logic                    strobe_q, strobe_d;
  logic signed [WIDTH-1:0] cur;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    en_d     = en_q;
    ready_d  = '0;
    sample_d = sample_q;
    strobe_d = 1'b0;
    ur_set   = '0;
    idx_nxt  = idx_q + 1'b1;
    cur      = src_data[idx_q*WIDTH +: WIDTH];
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d    = SCAN;
          idx_d      = '0;
          acc_d      = '0;
          en_d       = src_en;
          ready_d[0] = src_en[0];
        end
      end
      SCAN: begin
        if (ready_q[idx_q]) begin
          if (src_valid[idx_q]) acc_d = acc_q + ACC_W'(cur);
          else                  ur_set[idx_q] = 1'b1;
        end
        // Disabled sources still consume a slot to keep frame timing fixed.
        if (idx_q == LAST) begin
          state_d = SAT;
        end else begin
          idx_d            = idx_nxt;
          ready_d[idx_nxt] = en_q[idx_nxt];
        end
      end
      SAT: begin
        sample_d = WIDTH'(sat_trunc(64'(acc_q), ACC_W, WIDTH));
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    underrun_d = (underrun_q & ~{N_SRC{clr_underrun}}) | ur_set;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      en_q       <= '0;
      ready_q    <= '0;
      underrun_q <= '0;
      sample_q   <= '0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
    end
  end

  assign src_ready     = ready_q;
  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sample_mix_scheduler.sv
// Directed bench for sample_mix_scheduler: frame timing, mixing,
// saturation, underrun flags, enable mask, reset abort, cadence.
module tb_sample_mix_scheduler;

  localparam int N = 4;
  localparam int W = 24;
  localparam int P = 768;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_en;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           clr_underrun;
  logic [W-1:0]   sample_out;
  logic           sample_strobe;
  logic [N-1:0]   underrun;

  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  sample_mix_scheduler #(
    .N_SRC (N),
    .WIDTH (W),
    .PERIOD(P)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .src_en       (src_en),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .clr_underrun (clr_underrun),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; the period model is cyc % P.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    bit seen  = 1'b0;
    bit found = 1'b0;
    for (int k = 0; k < P + 2 && !found; k++) begin
      @(negedge clk);
      if (sample_strobe) seen = 1'b1;
      if (cyc % P == P - 1) found = 1'b1;
    end
    n_checks++;
    if (!found || seen) begin
      n_fail++;
      $display("FAIL wait_tick: tick_found=%0d stray_strobe=%0d required 1/0",
               found, seen);
    end
  endtask

  task automatic run_frame(
    input string          name,
    input logic [N-1:0]   en,
    input logic [N-1:0]   valid,
    input logic [N*W-1:0] data,
    input logic [W-1:0]   exp_out,
    input logic [N-1:0]   exp_ur,
    input int             clr_at,
    input bit             flip_en
  );
    logic [N-1:0] exp_rdy;
    logic [N-1:0] one;
    one = 1;
    wait_tick();
    src_en       = en;
    src_valid    = valid;
    src_data     = data;
    clr_underrun = 1'b0;
    for (int i = 1; i <= N + 2; i++) begin
      @(negedge clk);
      exp_rdy = '0;
      if (i <= N && en[i-1]) exp_rdy = one << (i - 1);
      n_checks++;
      if (src_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s ready T+%0d: got %b required %b",
                 name, i, src_ready, exp_rdy);
      end
      n_checks++;
      if (sample_strobe !== (i == N + 2)) begin
        n_fail++;
        $display("FAIL %s strobe T+%0d: got %b required %b",
                 name, i, sample_strobe, (i == N + 2));
      end
      if (i == 1 && flip_en) src_en = ~en;
      clr_underrun = (i == clr_at);
    end
    clr_underrun = 1'b0;
    src_en       = en;
    n_checks++;
    if (sample_out !== exp_out) begin
      n_fail++;
      $display("FAIL %s sample_out: got %h required %h", name, sample_out, exp_out);
    end
    n_checks++;
    if (underrun !== exp_ur) begin
      n_fail++;
      $display("FAIL %s underrun: got %b required %b", name, underrun, exp_ur);
    end
    @(negedge clk);
    n_checks++;
    if (sample_out !== exp_out || sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hold: got %h/%b required %h/0",
               name, sample_out, sample_strobe, exp_out);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    n_checks++;
    if (underrun !== '0) begin
      n_fail++;
      $display("FAIL clear: underrun got %b required 0000", underrun);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    src_en       = '0;
    src_valid    = '0;
    src_data     = '0;
    clr_underrun = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sample_out !== '0 || sample_strobe !== 1'b0 ||
        src_ready !== '0 || underrun !== '0) begin
      n_fail++;
      $display("FAIL reset: out=%h stb=%b rdy=%b ur=%b required all 0",
               sample_out, sample_strobe, src_ready, underrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame("basic", 4'b1111, 4'b1111,
              {24'd4, 24'd3, 24'd2, 24'd1}, 24'd10, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_saturation();
    run_frame("sat_pos", 4'b1111, 4'b1111,
              {24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF},
              24'h7FFFFF, 4'b0000, 0, 1'b0);
    run_frame("sat_neg", 4'b1111, 4'b1111,
              {24'h800000, 24'h800000, 24'h800000, 24'h800000},
              24'h800000, 4'b0000, 0, 1'b0);
    run_frame("sat_mix", 4'b1111, 4'b1111,
              {24'h000000, 24'h800000, 24'h000001, 24'h7FFFFF},
              24'h000000, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_underrun();
    run_frame("ur_set", 4'b1111, 4'b1011,
              {24'd8, 24'd7, 24'd6, 24'd5}, 24'd19, 4'b0100, 0, 1'b0);
    run_frame("ur_sticky", 4'b1111, 4'b1111,
              {24'd1, 24'd1, 24'd1, 24'd1}, 24'd4, 4'b0100, 0, 1'b0);
    pulse_clear();
    run_frame("ur_set_wins", 4'b1111, 4'b1011,
              {24'd8, 24'd7, 24'd6, 24'd5}, 24'd19, 4'b0100, 3, 1'b0);
    pulse_clear();
  endtask

  task automatic test_enable();
    run_frame("enable", 4'b0011, 4'b0011,
              {24'd4, 24'd3, 24'd2, 24'd1}, 24'd3, 4'b0000, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit stray = 1'b0;
    wait_tick();
    src_en    = 4'b1111;
    src_valid = 4'b1110;
    src_data  = {24'd4, 24'd3, 24'd2, 24'd1};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample_out !== '0 || src_ready !== '0 || underrun !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h rdy=%b ur=%b required 0",
               sample_out, src_ready, underrun);
    end
    repeat (4) begin
      @(negedge clk);
      if (sample_strobe) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL reset_mid strobe: got 1 required 0");
    end
    rst = 1'b0;
    run_frame("after_reset", 4'b1111, 4'b1111,
              {24'd4, 24'd3, 24'd2, 24'd1}, 24'd10, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_cadence();
    for (int k = 0; k < 32; k++) begin
      run_frame("cadence", 4'b1111, 4'b1111,
                {24'd0, 24'd0, 24'd0, 24'(k)}, 24'(k), 4'b0000, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_underrun();
    test_enable();
    test_reset_mid();
    test_cadence();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
